uart_hamming_tx: RTL



---
 rtl/uart_hamming_tx.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/uart_hamming_tx.sv
// uart_hamming_tx: SECDED-encodes bytes into 13-bit codewords and sends them
// as start + 13 data bits (LSB first) + stop on a serial line, with a
// one-entry holding register so frames can run back to back.
module uart_hamming_tx #(
  parameter int divisor = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  data_in,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        frame,
  output logic        busy,
  output logic        done,
  output logic [12:0] codeword
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Last count of a bit-time, and the count one before it so that the
  // registered done pulse lands on the final stop-bit cycle.
  localparam logic [10:0] LAST_TICK = 11'(divisor - 1);
  localparam logic [10:0] DONE_TICK = 11'(divisor - 2);

  state_t      state;
  logic [10:0] bit_cnt;
  logic [3:0]  bit_idx;
  logic        hold_full;
  logic [12:0] hold_cw;
  logic        accept;
  logic        load;

  function automatic logic [12:0] encode(input logic [7:0] d);
    logic [12:0] cw;
    cw       = '0;
    cw[2]    = d[0];
    cw[4]    = d[1];
    cw[5]    = d[2];
    cw[6]    = d[3];
    cw[11:8] = d[7:4];
    cw[0]    = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
    cw[1]    = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
    cw[3]    = d[1] ^ d[2] ^ d[3] ^ d[7];
    cw[7]    = d[4] ^ d[5] ^ d[6] ^ d[7];
    cw[12]   = ^cw[11:0];
    return cw;
  endfunction

  assign tx_ready = !hold_full;
  assign accept   = tx_valid && tx_ready;
  // A queued codeword moves to the line either from IDLE or straight out of
  // the last stop-bit cycle, which is what makes back-to-back frames gapless.
  assign load     = hold_full &&
                    ((state == IDLE) || ((state == STOP) && (bit_cnt == LAST_TICK)));

  // Holding register: stores the already-encoded codeword of an accepted byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_full <= 1'b0;
      hold_cw   <= '0;
    end else if (load) begin
      hold_full <= 1'b0;
    end else if (accept) begin
      hold_full <= 1'b1;
      hold_cw   <= encode(data_in);
    end
  end

  // Frame sequencer with registered line, busy and done outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      bit_idx  <= '0;
      frame    <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      codeword <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          frame   <= 1'b1;
          busy    <= 1'b0;
          bit_cnt <= '0;
          if (load) begin
            state    <= START;
            frame    <= 1'b0;
            busy     <= 1'b1;
            codeword <= hold_cw;
          end
        end
        START: begin
          if (bit_cnt == LAST_TICK) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            state   <= DATA;
            frame   <= codeword[0];
          end else begin
            bit_cnt <= bit_cnt + 11'd1;
          end
        end
        DATA: begin
          if (bit_cnt == LAST_TICK) begin
            bit_cnt <= '0;
            if (bit_idx == 4'd12) begin
              state <= STOP;
              frame <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 4'd1;
              frame   <= codeword[bit_idx + 4'd1];
            end
          end else begin
            bit_cnt <= bit_cnt + 11'd1;
          end
        end
        STOP: begin
          if (bit_cnt == LAST_TICK) begin
            bit_cnt <= '0;
            if (load) begin
              state    <= START;
              frame    <= 1'b0;
              codeword <= hold_cw;
            end else begin
              state <= IDLE;
              frame <= 1'b1;
              busy  <= 1'b0;
            end
          end else begin
            bit_cnt <= bit_cnt + 11'd1;
            if (bit_cnt == DONE_TICK) begin
              done <= 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          frame   <= 1'b1;
          busy    <= 1'b0;
          bit_cnt <= '0;
          bit_idx <= '0;
        end
      endcase
    end
  end

endmodule
